cu_sequencer: RTL and testbench
===============================

CU_SEQUENCER -- requirements
Module: cu_sequencer

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising-edge; RST_N  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: CU_OPCODE  in  7  opcode of latched instruction; FUNC3  in  3  instruction funct3.
REQ-003 SHALL have ports: MEM_READY  in  1  memory completes the current request; INTR  in  1  level interrupt request; MIE  in  1  interrupt enable from CSR unit.
REQ-004 SHALL have ports: PC_WRITE, REG_WRITE, MEM_RDEN1 (instruction read), MEM_RDEN2 (data read), MEM_WE2 (data write), CSR_WRITE, INT_TAKEN, ILLEGAL, BUS_ERR  out  1 each.
REQ-005 SHALL have parameter: WAIT_MAX, default 15, meaning the maximum MEM_READY wait cycles before bus error (range 1..15).

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, EXEC, MEM_WAIT, WRITEBACK, INTERRUPT; outputs depend only on state, latched flags and MEM_READY.
REQ-007 FETCH: MEM_RDEN1=1; MEM_READY=1 -> EXEC; otherwise stay.
REQ-008 EXEC, LOAD (0000011): MEM_RDEN2=1, set is_load flag -> MEM_WAIT.
REQ-009 EXEC, STORE (0100011): MEM_WE2=1, clear is_load flag -> MEM_WAIT.
REQ-010 EXEC, BRANCH (1100011): PC_WRITE=1, REG_WRITE=0.
REQ-011 EXEC, LUI/AUIPC/JAL/JALR/OP/OP_IMM: PC_WRITE=1, REG_WRITE=1.
REQ-012 EXEC, SYSTEM (1110011): PC_WRITE=1, REG_WRITE=1; CSR_WRITE=1 only when FUNC3=001.
REQ-013 EXEC, any other opcode: PC_WRITE=1, ILLEGAL=1 for one cycle, no REG_WRITE.
REQ-014 MEM_WAIT: hold MEM_RDEN2 (load) or MEM_WE2 (store) until MEM_READY; on MEM_READY a load -> WRITEBACK, a store asserts PC_WRITE=1 that cycle.
REQ-015 WRITEBACK: REG_WRITE=1, PC_WRITE=1, one cycle.
REQ-016 Instruction-completion cycle = any cycle asserting PC_WRITE outside INTERRUPT; next state is INTERRUPT if INTR&MIE in that cycle, else FETCH.
REQ-017 INTERRUPT: INT_TAKEN=1, PC_WRITE=1, one cycle -> FETCH unconditionally (no nested take).
REQ-018 A 4-bit wait counter SHALL clear on entry to FETCH or MEM_WAIT and increment each cycle MEM_READY=0 in those states.
REQ-019 Counter reaching WAIT_MAX with MEM_READY=0 SHALL pulse BUS_ERR for one cycle, drop the request, assert PC_WRITE=1 and complete the instruction per REQ-016 (no REG_WRITE).
REQ-020 MEM_READY in the same cycle the counter reaches WAIT_MAX SHALL complete normally, with no BUS_ERR.
REQ-021 MEM_READY outside FETCH/MEM_WAIT SHALL be ignored; INTR outside completion cycles SHALL be ignored.
REQ-022 At most one of MEM_RDEN1, MEM_RDEN2, MEM_WE2 SHALL be high in any cycle.

Reset
REQ-023 RST_N low SHALL immediately force state FETCH, counter 0, is_load 0, and all outputs 0 (including MEM_RDEN1) while low.
REQ-024 After RST_N deasserts, the first rising edge SHALL see FETCH with MEM_RDEN1=1; reset mid-MEM_WAIT SHALL abandon the access without write or BUS_ERR.

Structure
REQ-025 opcode_t (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM) and cu_state_t SHALL live in the shared package otter_pkg, shared with the decoder.
REQ-026 The wait counter and timeout compare SHALL be one sub-module, cu_wait_timer (ports CLK, RST_N, CLR, INC, TIMEOUT).

Verification
REQ-027 OP 0110011, MEM_READY=1 in FETCH -> FETCH,EXEC: 2 cycles, EXEC has PC_WRITE=1, REG_WRITE=1.
REQ-028 LOAD, MEM_READY low 3 cycles in MEM_WAIT -> MEM_RDEN2 high 4 cycles, WRITEBACK REG_WRITE=1, PC_WRITE=1; total 7 cycles.
REQ-029 STORE with INTR=1, MIE=1 at completion -> MEM_WE2 then INTERRUPT with INT_TAKEN=1, PC_WRITE=1, then FETCH; INTR=1, MIE=0 -> no INT_TAKEN.
REQ-030 MEM_READY held 0 in FETCH, WAIT_MAX=15 -> BUS_ERR pulse on 15th wait cycle, PC_WRITE=1, back to FETCH; MEM_READY=1 on that cycle instead -> EXEC, no BUS_ERR.
REQ-031 Opcode 1111111 -> ILLEGAL=1, PC_WRITE=1, REG_WRITE=0; SYSTEM FUNC3=001 -> CSR_WRITE=1; FUNC3=010 -> CSR_WRITE=0.
REQ-032 RST_N low in MEM_WAIT of a store -> MEM_WE2 drops asynchronously, all outputs 0, FETCH after release.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER types: instruction opcodes and control-unit sequencer states.
package otter_pkg;

    typedef enum logic [6:0] {
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111,
        BRANCH = 7'b1100011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        OP_IMM = 7'b0010011,
        OP     = 7'b0110011,
        SYSTEM = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM_WAIT,
        WRITEBACK,
        INTERRUPT
    } cu_state_t;

    // funct3 of a SYSTEM instruction that writes a CSR (csrrw)
    localparam logic [2:0] FUNC3_CSRRW = 3'b001;

    // States in which the sequencer is waiting on MEM_READY
    function automatic logic is_wait_state(input cu_state_t s);
        return (s == FETCH) || (s == MEM_WAIT);
    endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Control-unit bundle: decoded instruction fields, memory handshake,
// interrupt request and the strobes the sequencer drives back.
interface cu_sequencer_if;

    logic [6:0] CU_OPCODE;
    logic [2:0] FUNC3;
    logic       MEM_READY;
    logic       INTR;
    logic       MIE;

    logic       PC_WRITE;
    logic       REG_WRITE;
    logic       MEM_RDEN1;
    logic       MEM_RDEN2;
    logic       MEM_WE2;
    logic       CSR_WRITE;
    logic       INT_TAKEN;
    logic       ILLEGAL;
    logic       BUS_ERR;

    // The sequencer side
    modport master (
        input  CU_OPCODE, FUNC3, MEM_READY, INTR, MIE,
        output PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
               CSR_WRITE, INT_TAKEN, ILLEGAL, BUS_ERR
    );

    // The datapath / memory side
    modport slave (
        output CU_OPCODE, FUNC3, MEM_READY, INTR, MIE,
        input  PC_WRITE, REG_WRITE, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
               CSR_WRITE, INT_TAKEN, ILLEGAL, BUS_ERR
    );

endinterface

// File: rtl/cu_wait_timer.sv
// Counts MEM_READY wait cycles and flags the cycle on which the wait limit
// is reached while memory is still not ready.
module cu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    input  logic INC,
    output logic TIMEOUT
);

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_MAX - 1);

    logic [3:0] count_q;

    // Wait counter: clear has priority, otherwise count one per stalled cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else if (CLR) begin
            count_q <= '0;
        end else if (INC) begin
            count_q <= count_q + 4'd1;
        end
    end

    assign TIMEOUT = INC && (count_q == LAST_WAIT);

endmodule

// File: rtl/cu_sequencer.sv
// Multi-cycle control-unit sequencer: fetch, execute, memory wait,
// writeback and interrupt entry, with a bus-error timeout on memory waits.
module cu_sequencer
    import otter_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic CLK,
    input  logic RST_N,
    cu_sequencer_if.master bus
);

    cu_state_t state_q, state_d;
    logic      is_load_q, is_load_d;

    logic wait_inc, wait_clr, timeout, complete;
    logic pc_write, reg_write, rden1, rden2, we2;
    logic csr_write, int_taken, illegal, bus_err;

    // Count only while stalled in a wait state; any exit restarts from zero
    assign wait_inc = is_wait_state(state_q) && !bus.MEM_READY;
    assign wait_clr = !wait_inc || timeout;

    cu_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .CLR     (wait_clr),
        .INC     (wait_inc),
        .TIMEOUT (timeout)
    );

    // State register and the load/store flag remembered across MEM_WAIT
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= FETCH;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
        end
    end

    // Next-state and strobe decode; completion cycles may divert to INTERRUPT
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        complete  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        rden1     = 1'b0;
        rden2     = 1'b0;
        we2       = 1'b0;
        csr_write = 1'b0;
        int_taken = 1'b0;
        illegal   = 1'b0;
        bus_err   = 1'b0;

        case (state_q)
            FETCH: begin
                if (timeout) begin
                    bus_err  = 1'b1;
                    pc_write = 1'b1;
                    complete = 1'b1;
                end else begin
                    rden1 = 1'b1;
                    if (bus.MEM_READY) begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                case (bus.CU_OPCODE)
                    LOAD: begin
                        rden2     = 1'b1;
                        is_load_d = 1'b1;
                        state_d   = MEM_WAIT;
                    end
                    STORE: begin
                        we2       = 1'b1;
                        is_load_d = 1'b0;
                        state_d   = MEM_WAIT;
                    end
                    BRANCH: begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                    LUI, AUIPC, JAL, JALR, OP, OP_IMM: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        complete  = 1'b1;
                    end
                    SYSTEM: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        csr_write = (bus.FUNC3 == FUNC3_CSRRW);
                        complete  = 1'b1;
                    end
                    default: begin
                        pc_write = 1'b1;
                        illegal  = 1'b1;
                        complete = 1'b1;
                    end
                endcase
            end
            MEM_WAIT: begin
                if (timeout) begin
                    bus_err  = 1'b1;
                    pc_write = 1'b1;
                    complete = 1'b1;
                end else if (bus.MEM_READY) begin
                    if (is_load_q) begin
                        state_d = WRITEBACK;
                    end else begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                end else begin
                    rden2 = is_load_q;
                    we2   = !is_load_q;
                end
            end
            WRITEBACK: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                complete  = 1'b1;
            end
            INTERRUPT: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_d   = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        if (complete) begin
            state_d = (bus.INTR && bus.MIE) ? INTERRUPT : FETCH;
        end
    end

    // While reset is held every strobe is forced low, including the fetch read
    assign bus.PC_WRITE  = RST_N && pc_write;
    assign bus.REG_WRITE = RST_N && reg_write;
    assign bus.MEM_RDEN1 = RST_N && rden1;
    assign bus.MEM_RDEN2 = RST_N && rden2;
    assign bus.MEM_WE2   = RST_N && we2;
    assign bus.CSR_WRITE = RST_N && csr_write;
    assign bus.INT_TAKEN = RST_N && int_taken;
    assign bus.ILLEGAL   = RST_N && illegal;
    assign bus.BUS_ERR   = RST_N && bus_err;

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: a per-instruction trace model built
// from the cycle rules of each instruction class, compared cycle by cycle.
module tb_cu_sequencer;

    localparam int WAIT_MAX = 15;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Output vector bit masks: {PCW,RGW,RD1,RD2,WE2,CSR,INT,ILL,BER}
    localparam logic [8:0] M_PCW = 9'h100;
    localparam logic [8:0] M_RGW = 9'h080;
    localparam logic [8:0] M_RD1 = 9'h040;
    localparam logic [8:0] M_RD2 = 9'h020;
    localparam logic [8:0] M_WE2 = 9'h010;
    localparam logic [8:0] M_CSR = 9'h008;
    localparam logic [8:0] M_INT = 9'h004;
    localparam logic [8:0] M_ILL = 9'h002;
    localparam logic [8:0] M_BER = 9'h001;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    cu_sequencer_if bus();

    cu_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [8:0] obs_vec;
    assign obs_vec = {bus.PC_WRITE, bus.REG_WRITE, bus.MEM_RDEN1, bus.MEM_RDEN2,
                      bus.MEM_WE2, bus.CSR_WRITE, bus.INT_TAKEN, bus.ILLEGAL, bus.BUS_ERR};

    typedef struct packed {
        logic       ready;
        logic [8:0] want;
    } cyc_t;

    cyc_t       trace_q[$];
    logic [8:0] obs_q[$];

    function automatic void push_cyc(input logic r, input logic [8:0] w);
        trace_q.push_back({r, w});
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Result of the single execute cycle for a non-memory instruction
    function automatic logic [8:0] exec_result(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            OPC_BRANCH: return M_PCW;
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OPIMM: return M_PCW | M_RGW;
            OPC_SYSTEM: return M_PCW | M_RGW | ((f3 == 3'b001) ? M_CSR : 9'h000);
            default:    return M_PCW | M_ILL;
        endcase
    endfunction

    // Expected cycle list for one instruction: fw/mw are memory stall counts,
    // a count of WAIT_MAX or more means memory never answers
    function automatic void model_instr(input logic [6:0] opc, input logic [2:0] f3,
                                        input int fw, input int mw, input logic take_irq);
        logic       is_mem;
        logic [8:0] req;
        is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
        req    = (opc == OPC_LOAD) ? M_RD2 : M_WE2;
        if (fw >= WAIT_MAX) begin
            repeat (WAIT_MAX - 1) push_cyc(1'b0, M_RD1);
            push_cyc(1'b0, M_PCW | M_BER);
        end else begin
            repeat (fw) push_cyc(1'b0, M_RD1);
            push_cyc(1'b1, M_RD1);
            if (!is_mem) begin
                push_cyc(rnd_bit(), exec_result(opc, f3));
            end else begin
                push_cyc(rnd_bit(), req);
                if (mw >= WAIT_MAX) begin
                    repeat (WAIT_MAX - 1) push_cyc(1'b0, req);
                    push_cyc(1'b0, M_PCW | M_BER);
                end else begin
                    repeat (mw) push_cyc(1'b0, req);
                    if (opc == OPC_LOAD) begin
                        push_cyc(1'b1, 9'h000);
                        push_cyc(rnd_bit(), M_PCW | M_RGW);
                    end else begin
                        push_cyc(1'b1, M_PCW);
                    end
                end
            end
        end
        if (take_irq) push_cyc(rnd_bit(), M_INT | M_PCW);
    endfunction

    // Run one instruction from FETCH, recording outputs on each falling edge
    task automatic exercise(input logic [6:0] opc, input logic [2:0] f3, input int fw,
                            input int mw, input logic intr, input logic mie);
        bus.CU_OPCODE = opc;
        bus.FUNC3     = f3;
        bus.INTR      = intr;
        bus.MIE       = mie;
        trace_q.delete();
        obs_q.delete();
        model_instr(opc, f3, fw, mw, intr && mie);
        foreach (trace_q[i]) begin
            bus.MEM_READY = trace_q[i].ready;
            @(negedge CLK);
            obs_q.push_back(obs_vec);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.CU_OPCODE = 7'($urandom);
        bus.FUNC3     = 3'($urandom);
        bus.INTR      = 1'b1;
        bus.MIE       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MEM_READY = rnd_bit();
            @(negedge CLK);
            checks++;
            if (obs_vec !== 9'h000) begin
                failures++;
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected %b", i, obs_vec, 9'h000);
            end
        end
        @(posedge CLK);
        #1;
        RST_N         = 1'b1;
        bus.INTR      = 1'b0;
        bus.MIE       = 1'b0;
        bus.MEM_READY = 1'b1;
        bus.CU_OPCODE = OPC_OP;
        @(negedge CLK);
        checks++;
        if (obs_vec !== M_RD1) begin
            failures++;
            $display("[TB] FAIL reset_release_fetch: got %b expected %b", obs_vec, M_RD1);
        end
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checks++;
        if (obs_vec !== (M_PCW | M_RGW)) begin
            failures++;
            $display("[TB] FAIL reset_release_exec: got %b expected %b", obs_vec, M_PCW | M_RGW);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [7] = '{OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH};
        for (int k = 0; k < 7; k++) begin
            exercise(ops[k], 3'($urandom), (k == 0) ? 0 : $urandom_range(0, 3), 0, rnd_bit(), 1'b0);
            foreach (trace_q[i]) begin
                checks++;
                if (obs_q[i] !== trace_q[i].want) begin
                    failures++;
                    $display("[TB] FAIL alu op=%b cycle %0d: got %b expected %b", ops[k], i, obs_q[i], trace_q[i].want);
                end
            end
        end
    endtask

    task automatic test_load_store();
        int n_rd2;
        exercise(OPC_LOAD, 3'b010, 0, 3, 1'b0, 1'b0);
        n_rd2 = 0;
        foreach (trace_q[i]) begin
            n_rd2 += int'(obs_q[i][5]);
            checks++;
            if (obs_q[i] !== trace_q[i].want) begin
                failures++;
                $display("[TB] FAIL load3 cycle %0d: got %b expected %b", i, obs_q[i], trace_q[i].want);
            end
        end
        checks++;
        if (n_rd2 !== 4) begin
            failures++;
            $display("[TB] FAIL load3_rden2_cycles: got %0d expected 4", n_rd2);
        end
        for (int k = 0; k < 6; k++) begin
            exercise((k % 2 == 0) ? OPC_STORE : OPC_LOAD, 3'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 4), 1'b0, rnd_bit());
            foreach (trace_q[i]) begin
                checks++;
                if (obs_q[i] !== trace_q[i].want) begin
                    failures++;
                    $display("[TB] FAIL ldst k=%0d cycle %0d: got %b expected %b", k, i, obs_q[i], trace_q[i].want);
                end
            end
        end
    endtask

    task automatic test_interrupt();
        int n_int;
        for (int k = 0; k < 4; k++) begin
            exercise((k < 2) ? OPC_STORE : OPC_OP, 3'b000, 1, 2, 1'b1, (k % 2 == 0));
            n_int = 0;
            foreach (trace_q[i]) begin
                n_int += int'(obs_q[i][2]);
                checks++;
                if (obs_q[i] !== trace_q[i].want) begin
                    failures++;
                    $display("[TB] FAIL irq k=%0d cycle %0d: got %b expected %b", k, i, obs_q[i], trace_q[i].want);
                end
            end
            checks++;
            if (n_int !== ((k % 2 == 0) ? 1 : 0)) begin
                failures++;
                $display("[TB] FAIL irq_count k=%0d: got %0d expected %0d", k, n_int, (k % 2 == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_timeout();
        logic [6:0] opc [5] = '{OPC_OP, OPC_OP, OPC_LOAD, OPC_STORE, OPC_STORE};
        int         fw  [5] = '{WAIT_MAX, WAIT_MAX - 1, 0, 1, 0};
        int         mw  [5] = '{0, 0, WAIT_MAX, WAIT_MAX - 1, WAIT_MAX};
        logic       irq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            exercise(opc[k], 3'b000, fw[k], mw[k], irq[k], 1'b1);
            foreach (trace_q[i]) begin
                checks++;
                if (obs_q[i] !== trace_q[i].want) begin
                    failures++;
                    $display("[TB] FAIL timeout k=%0d cycle %0d: got %b expected %b", k, i, obs_q[i], trace_q[i].want);
                end
            end
        end
    endtask

    task automatic test_illegal_csr();
        logic [6:0] opc [4] = '{7'b1111111, OPC_SYSTEM, OPC_SYSTEM, 7'b0001111};
        logic [2:0] f3  [4] = '{3'b000, 3'b001, 3'b010, 3'b001};
        for (int k = 0; k < 4; k++) begin
            exercise(opc[k], f3[k], 0, 0, 1'b0, 1'b0);
            foreach (trace_q[i]) begin
                checks++;
                if (obs_q[i] !== trace_q[i].want) begin
                    failures++;
                    $display("[TB] FAIL illcsr k=%0d cycle %0d: got %b expected %b", k, i, obs_q[i], trace_q[i].want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [8:0] want [6] = '{M_RD1, M_WE2, M_WE2, 9'h000, M_RD1, M_PCW | M_RGW};
        logic [8:0] got  [6];
        bus.INTR      = 1'b0;
        bus.MIE       = 1'b0;
        bus.CU_OPCODE = OPC_STORE;
        bus.MEM_READY = 1'b1;
        @(negedge CLK); got[0] = obs_vec;
        @(posedge CLK); #1;
        bus.MEM_READY = 1'b0;
        @(negedge CLK); got[1] = obs_vec;
        @(posedge CLK); #1;
        @(negedge CLK); got[2] = obs_vec;
        #1 RST_N = 1'b0;
        #1 got[3] = obs_vec;
        @(posedge CLK); #1;
        RST_N         = 1'b1;
        bus.MEM_READY = 1'b1;
        bus.CU_OPCODE = OPC_OP;
        @(negedge CLK); got[4] = obs_vec;
        @(posedge CLK); #1;
        @(negedge CLK); got[5] = obs_vec;
        @(posedge CLK); #1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                failures++;
                $display("[TB] FAIL reset_mid_store step %0d: got %b expected %b", i, got[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                 OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM};
        logic [6:0] opc;
        int         fw, mw;
        for (int k = 0; k < 40; k++) begin
            opc = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)];
            fw  = ($urandom_range(0, 9) == 0) ? WAIT_MAX + $urandom_range(0, 2) : $urandom_range(0, 3);
            mw  = ($urandom_range(0, 7) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
            exercise(opc, 3'($urandom), fw, mw, rnd_bit(), rnd_bit());
            foreach (trace_q[i]) begin
                checks++;
                if (obs_q[i] !== trace_q[i].want) begin
                    failures++;
                    $display("[TB] FAIL random k=%0d op=%b cycle %0d: got %b expected %b", k, opc, i, obs_q[i], trace_q[i].want);
                end
                checks++;
                if ($countones(obs_q[i][6:4]) > 1) begin
                    failures++;
                    $display("[TB] FAIL random_onehot k=%0d cycle %0d: got %b expected at most one request", k, i, obs_q[i][6:4]);
                end
            end
        end
    endtask

    initial begin
        bus.CU_OPCODE = '0;
        bus.FUNC3     = '0;
        bus.MEM_READY = 1'b0;
        bus.INTR      = 1'b0;
        bus.MIE       = 1'b0;
        test_reset();
        test_alu_ops();
        test_load_store();
        test_interrupt();
        test_timeout();
        test_illegal_csr();
        test_reset_mid_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
